// File: rtl/replay_expander.sv
// Receive side of the time-multiplexed macro column: captures one compressed gamma window
// in a ping-pong store and replays it next window as two zero-inserted spike streams.
module replay_expander #(
   parameter int P            = 64,
   parameter int BUFFER_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_count,
   input  logic         gamma_start,
   input  logic [P-1:0] data_in,
   output logic [P-1:0] data_out0,
   output logic [P-1:0] data_out1,
   output logic         out_valid
);

   localparam int HALF   = BUFFER_DEPTH / 2;
   localparam int IDX_W  = $clog2(BUFFER_DEPTH);
   localparam int ADDR_W = $clog2(HALF);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  e;
   logic              wsel;
   logic              abort;
   logic              last;
   logic              wr_en;
   logic              wr_vc;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [P-1:0]      rd0;
   logic [P-1:0]      rd1;

   // [bank][virtual column][entry]
   logic [P-1:0] bank [2][2][HALF];

   // The window index restarts on any gamma_start so a premature pulse realigns the window.
   always_comb begin
      e       = (state == IDLE || gamma_start) ? '0 : idx_q;
      last    = (e == IDX_W'(BUFFER_DEPTH - 1));
      abort   = (state == RUN) && gamma_start && (idx_q != '0);
      wr_en   = rst && start_count && (state != IDLE || gamma_start);
      wr_vc   = (e >= IDX_W'(HALF));
      wr_addr = wr_vc ? ADDR_W'(e - IDX_W'(HALF)) : ADDR_W'(e);
      rd_addr = ADDR_W'(e >> 1);
      rd0     = bank[~wsel][0][rd_addr];
      rd1     = bank[~wsel][1][rd_addr];
   end

   // NOTE: the store has no reset; FILL always rewrites a bank before it can be read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank[wsel][wr_vc][wr_addr] <= data_in;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         idx_q     <= '0;
         wsel      <= 1'b0;
         data_out0 <= '0;
         data_out1 <= '0;
         out_valid <= 1'b0;
      end else if (!start_count) begin
         state     <= IDLE;
         idx_q     <= '0;
         data_out0 <= '0;
         data_out1 <= '0;
         out_valid <= 1'b0;
      end else begin
         idx_q     <= last ? '0 : e + IDX_W'(1);
         data_out0 <= '0;
         data_out1 <= '0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (gamma_start) begin
                  state <= FILL;
               end else begin
                  idx_q <= '0;
               end
            end
            FILL: begin
               if (last) begin
                  wsel  <= ~wsel;
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= FILL;
               end else begin
                  out_valid <= 1'b1;
                  data_out0 <= e[0] ? '0 : rd0;
                  data_out1 <= e[0] ? '0 : rd1;
                  if (last) begin
                     wsel <= ~wsel;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_replay_expander.sv
// Scoreboard bench for replay_expander: stimulus pushes the expected registered outputs for
// every clock, a monitor pops one entry per clock on the falling edge and compares.
module tb_replay_expander;

   localparam int P    = 8;
   localparam int BD   = 16;
   localparam int HALF = BD / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_count;
   logic         gamma_start;
   logic [P-1:0] data_in;
   logic [P-1:0] data_out0;
   logic [P-1:0] data_out1;
   logic         out_valid;

   typedef struct {
      logic       v;
      logic [7:0] o0;
      logic [7:0] o1;
      int         ph;
      int         cy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   phase  = 0;
   int   cyc    = 0;

   replay_expander #(.P(P), .BUFFER_DEPTH(BD)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_count (start_count),
      .gamma_start (gamma_start),
      .data_in     (data_in),
      .data_out0   (data_out0),
      .data_out1   (data_out1),
      .out_valid   (out_valid)
   );

   always #5 clk = ~clk;

   function automatic string phase_name(input int ph);
      case (ph)
         0:       return "reset_hold";
         1:       return "basic";
         2:       return "pingpong";
         3:       return "abort";
         4:       return "start_drop";
         5:       return "mid_reset";
         default: return "other";
      endcase
   endfunction

   task automatic check(input string name, input int cy, input logic [7:0] act,
                        input logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %02h, expected %02h", name, cy, act, want);
      end
   endtask

   // One clock of stimulus; the expected values are the outputs registered at this edge.
   task automatic drive(input logic r, input logic sc, input logic gs, input logic [7:0] d,
                        input logic ev, input logic [7:0] e0, input logic [7:0] e1);
      exp_t x;
      x.v  = ev;
      x.o0 = e0;
      x.o1 = e1;
      x.ph = phase;
      x.cy = cyc;
      exp_q.push_back(x);
      cyc++;
      rst         = r;
      start_count = sc;
      gamma_start = gs;
      data_in     = d;
      @(posedge clk);
      #1;
   endtask

   // One window (or its first len cycles) with gamma_start at index 0. Data is wbase(+idx).
   // When rep is set, the previous window (rbase(+idx)) is expected back zero-inserted.
   task automatic window(input logic [7:0] wbase, input bit winc, input int len,
                         input bit rep, input logic [7:0] rbase, input bit rinc);
      for (int j = 0; j < len; j++) begin
         logic [7:0] d;
         logic [7:0] e0;
         logic [7:0] e1;
         d  = wbase + (winc ? 8'(j) : 8'h00);
         e0 = 8'h00;
         e1 = 8'h00;
         if (rep && (j % 2 == 0)) begin
            e0 = rbase + (rinc ? 8'(j / 2) : 8'h00);
            e1 = rbase + (rinc ? 8'(HALF + j / 2) : 8'h00);
         end
         drive(1'b1, 1'b1, (j == 0), d, logic'(rep), e0, e1);
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check({phase_name(x.ph), ".out_valid"}, x.cy, {7'b0, out_valid}, {7'b0, x.v});
            check({phase_name(x.ph), ".data_out0"}, x.cy, data_out0, x.o0);
            check({phase_name(x.ph), ".data_out1"}, x.cy, data_out1, x.o1);
         end
      end
   end

   initial begin
      rst         = 1'b0;
      start_count = 1'b0;
      gamma_start = 1'b0;
      data_in     = '0;

      // Reset hold with random activity, then released but not enabled.
      phase = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00);
      end
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, 8'h00, 8'h00);

      // Basic expansion: window 0 = 01..10, window 1 = zeros.
      phase = 1;
      window(8'h01, 1'b1, BD, 1'b0, 8'h00, 1'b0);
      window(8'h00, 1'b0, BD, 1'b1, 8'h01, 1'b1);

      // Back-to-back windows, each replayed exactly one window later.
      phase = 2;
      window(8'h00, 1'b1, BD, 1'b1, 8'h00, 1'b0);
      window(8'h80, 1'b1, BD, 1'b1, 8'h00, 1'b1);
      window(8'h40, 1'b1, BD, 1'b1, 8'h80, 1'b1);
      window(8'h10, 1'b1, BD, 1'b1, 8'h40, 1'b1);

      // Premature gamma_start at idx 5: remainder of the 0x10 replay and the 0x20 data vanish.
      phase = 3;
      window(8'h20, 1'b1, 5, 1'b1, 8'h10, 1'b1);
      window(8'h30, 1'b1, BD, 1'b0, 8'h00, 1'b0);
      window(8'h50, 1'b1, BD, 1'b1, 8'h30, 1'b1);

      // start_count dropped at idx 9, gamma_start ignored while disabled, then re-enabled.
      phase = 4;
      window(8'h60, 1'b1, 9, 1'b1, 8'h50, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 8'h00);
      window(8'h70, 1'b1, BD, 1'b0, 8'h00, 1'b0);
      window(8'hA0, 1'b1, BD, 1'b1, 8'h70, 1'b1);

      // One-cycle reset mid-RUN, then restart: nothing from before the reset comes out.
      phase = 5;
      window(8'hB0, 1'b1, 6, 1'b1, 8'hA0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 8'h00);
      window(8'hC0, 1'b1, BD, 1'b0, 8'h00, 1'b0);
      window(8'hD0, 1'b1, BD, 1'b1, 8'hC0, 1'b1);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
